// File: rtl/arrow_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// arrow_pkg : shared types and helpers for the arrow pool
// Rev 1.0
// ----------------------------------------------------------------
package arrow_pkg;

  typedef enum logic [1:0] {
    SIDE_TOP    = 2'b00,
    SIDE_BOTTOM = 2'b01,
    SIDE_LEFT   = 2'b10,
    SIDE_RIGHT  = 2'b11
  } side_e;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_e;

  localparam int DIST_W  = 10;
  localparam int COORD_W = 12;

  // Sides are paired so that flipping bit 0 yields the opposite side.
  function automatic side_e opposite_side(input side_e s);
    return side_e'(s ^ 2'b01);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arrow_slot.sv
`default_nettype none
// ----------------------------------------------------------------
// arrow_slot : one arrow's FREE/FLY state, frame update and box test
// Rev 1.0
// ----------------------------------------------------------------
module arrow_slot
  import arrow_pkg::*;
#(
  parameter int CENTER_X   = 512,
  parameter int CENTER_Y   = 384,
  parameter int START_DIST = 352,
  parameter int TURN_DIST  = 128,
  parameter int BLOCK_NEAR = 32,
  parameter int BLOCK_FAR  = 96,
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [1:0]        side_i,
  input  logic [DIST_W-1:0] step_i,
  input  logic              inverse_i,
  input  logic [1:0]        shield_i,
  input  logic [10:0]       hcount_i,
  input  logic [9:0]        vcount_i,
  output logic              active_o,
  output logic              in_box_o,
  output logic              inv_pending_o,
  output logic              block_o,
  output logic              hit_o
);

  localparam logic [DIST_W-1:0] START_D = DIST_W'(START_DIST);
  localparam logic [DIST_W-1:0] TURN_D  = DIST_W'(TURN_DIST);
  localparam logic [DIST_W-1:0] NEAR_D  = DIST_W'(BLOCK_NEAR);
  localparam logic [DIST_W-1:0] FAR_D   = DIST_W'(BLOCK_FAR);

  localparam logic signed [COORD_W-1:0] CX  = COORD_W'(CENTER_X);
  localparam logic signed [COORD_W-1:0] CY  = COORD_W'(CENTER_Y);
  localparam logic signed [COORD_W-1:0] HW  = COORD_W'(WIDTH / 2);
  localparam logic signed [COORD_W-1:0] W12 = COORD_W'(WIDTH);
  localparam logic signed [COORD_W-1:0] H12 = COORD_W'(HEIGHT);

  slot_state_e       state_q;
  side_e             side_q;
  logic [DIST_W-1:0] dist_q;
  logic [DIST_W-1:0] step_q;
  logic              inv_q;
  logic              block_q;
  logic              hit_q;

  logic [DIST_W-1:0] nd;
  logic              block_cond;

  assign nd         = (dist_q > step_q) ? (dist_q - step_q) : '0;
  assign block_cond = (shield_i == side_q) && (dist_q >= NEAR_D) && (dist_q <= FAR_D);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q <= SLOT_FREE;
      side_q  <= SIDE_TOP;
      dist_q  <= '0;
      step_q  <= '0;
      inv_q   <= 1'b0;
      block_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      block_q <= 1'b0;
      hit_q   <= 1'b0;
      case (state_q)
        SLOT_FREE: begin
          if (load_i) begin
            state_q <= SLOT_FLY;
            side_q  <= side_e'(side_i);
            dist_q  <= START_D;
            step_q  <= step_i;
            inv_q   <= inverse_i;
          end
        end
        SLOT_FLY: begin
          if (tick_i) begin
            if (block_cond) begin
              state_q <= SLOT_FREE;
              block_q <= 1'b1;
            end else if (inv_q && (nd <= TURN_D)) begin
              side_q <= opposite_side(side_q);
              dist_q <= TURN_D;
              inv_q  <= 1'b0;
            end else if (nd == '0) begin
              state_q <= SLOT_FREE;
              hit_q   <= 1'b1;
            end else begin
              dist_q <= nd;
            end
          end
        end
        default: state_q <= SLOT_FREE;
      endcase
    end
  end

  // Box is [lo, lo+size) per axis; the sprite trails away from centre behind its leading edge.
  logic signed [COORD_W-1:0] px, py, d, lo_x, lo_y, sz_x, sz_y;

  always_comb begin
    px = $signed({1'b0, hcount_i});
    py = $signed({2'b00, vcount_i});
    d  = $signed({2'b00, dist_q});
    lo_x = CX - HW;
    lo_y = CY - d - H12;
    sz_x = W12;
    sz_y = H12;
    case (side_q)
      SIDE_TOP:    begin lo_x = CX - HW;     lo_y = CY - d - H12; sz_x = W12; sz_y = H12; end
      SIDE_BOTTOM: begin lo_x = CX - HW;     lo_y = CY + d;       sz_x = W12; sz_y = H12; end
      SIDE_LEFT:   begin lo_x = CX - d - H12; lo_y = CY - HW;     sz_x = H12; sz_y = W12; end
      default:     begin lo_x = CX + d;       lo_y = CY - HW;     sz_x = H12; sz_y = W12; end
    endcase
  end

  assign active_o      = (state_q == SLOT_FLY);
  assign inv_pending_o = active_o && inv_q;
  assign in_box_o      = active_o && (px >= lo_x) && (px < lo_x + sz_x)
                                  && (py >= lo_y) && (py < lo_y + sz_y);
  assign block_o       = block_q;
  assign hit_o         = hit_q;

endmodule
`default_nettype wire

// File: rtl/arrow_pool.sv
`default_nettype none
// ----------------------------------------------------------------
// arrow_pool : NUM_ARROWS arrow slots with allocator, render mux, pulses
// Rev 1.0
// ----------------------------------------------------------------
module arrow_pool
  import arrow_pkg::*;
#(
  parameter int          NUM_ARROWS = 4,
  parameter int          CENTER_X   = 512,
  parameter int          CENTER_Y   = 384,
  parameter int          START_DIST = 352,
  parameter int          SPEED_UNIT = 2,
  parameter int          TURN_DIST  = 128,
  parameter int          BLOCK_NEAR = 32,
  parameter int          BLOCK_FAR  = 96,
  parameter int          WIDTH      = 8,
  parameter int          HEIGHT     = 32,
  parameter logic [11:0] COLOR      = 12'hF00,
  parameter logic [11:0] COLOR_INV  = 12'h0CF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [10:0]                         hcount_in,
  input  logic [9:0]                          vcount_in,
  input  logic                                clear_in,
  input  logic                                spawn_valid,
  output logic                                spawn_ready,
  input  logic [1:0]                          spawn_side,
  input  logic [2:0]                          spawn_speed,
  input  logic                                spawn_inverse,
  input  logic [1:0]                          shield_dir_in,
  output logic [11:0]                         pixel_out,
  output logic                                valid_out,
  output logic                                blocked,
  output logic                                hit_player,
  output logic [NUM_ARROWS-1:0]               blocked_mask,
  output logic [NUM_ARROWS-1:0]               hit_mask,
  output logic [$clog2(NUM_ARROWS+1)-1:0]     active_count
);

  localparam int CNT_W = $clog2(NUM_ARROWS + 1);

  logic [NUM_ARROWS-1:0] slot_active, slot_in_box, slot_inv, slot_blk, slot_hit, slot_load;
  logic [2:0]            speed_eff;
  logic [DIST_W-1:0]     spawn_step;
  logic                  tick, accept, found;

  logic                  valid_d, valid_q;
  logic [11:0]           pixel_d, pixel_q;
  logic [CNT_W-1:0]      count_d, count_q;

  assign tick        = (hcount_in == '0) && (vcount_in == '0);
  assign spawn_ready = !rst && (|(~slot_active));
  assign accept      = spawn_valid && spawn_ready && !clear_in;
  assign speed_eff   = (spawn_speed == 3'd0) ? 3'd1 : spawn_speed;
  assign spawn_step  = DIST_W'(speed_eff) * DIST_W'(SPEED_UNIT);

  always_comb begin
    slot_load = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      if (!found && !slot_active[i]) begin
        slot_load[i] = accept;
        found        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_ARROWS; g++) begin : g_slot
    arrow_slot #(
      .CENTER_X  (CENTER_X),
      .CENTER_Y  (CENTER_Y),
      .START_DIST(START_DIST),
      .TURN_DIST (TURN_DIST),
      .BLOCK_NEAR(BLOCK_NEAR),
      .BLOCK_FAR (BLOCK_FAR),
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear_in),
      .tick_i       (tick),
      .load_i       (slot_load[g]),
      .side_i       (spawn_side),
      .step_i       (spawn_step),
      .inverse_i    (spawn_inverse),
      .shield_i     (shield_dir_in),
      .hcount_i     (hcount_in),
      .vcount_i     (vcount_in),
      .active_o     (slot_active[g]),
      .in_box_o     (slot_in_box[g]),
      .inv_pending_o(slot_inv[g]),
      .block_o      (slot_blk[g]),
      .hit_o        (slot_hit[g])
    );
  end

  // Scan from the top index down so the lowest matching slot is the last writer.
  always_comb begin
    valid_d = 1'b0;
    pixel_d = '0;
    for (int i = NUM_ARROWS - 1; i >= 0; i--) begin
      if (slot_in_box[i]) begin
        valid_d = 1'b1;
        pixel_d = slot_inv[i] ? COLOR_INV : COLOR;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      count_d = count_d + CNT_W'(slot_active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_in) begin
      valid_q <= 1'b0;
      pixel_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      pixel_q <= pixel_d;
      count_q <= count_d;
    end
  end

  assign valid_out    = valid_q;
  assign pixel_out    = pixel_q;
  assign active_count = count_q;
  assign blocked_mask = slot_blk;
  assign hit_mask     = slot_hit;
  assign blocked      = |slot_blk;
  assign hit_player   = |slot_hit;

endmodule
`default_nettype wire

// File: tb/tb_arrow_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------
// tb_arrow_pool : directed stimulus, behavioural model, per-cycle compare
// Rev 1.0
// ----------------------------------------------------------------
module tb_arrow_pool;

  localparam int N      = 4;
  localparam int IDLE_H = 2000;
  localparam int IDLE_V = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   hcount_in = 11'(IDLE_H);
  logic [9:0]    vcount_in = 10'(IDLE_V);
  logic          clear_in = 1'b0;
  logic          spawn_valid = 1'b0;
  logic          spawn_ready;
  logic [1:0]    spawn_side = 2'd0;
  logic [2:0]    spawn_speed = 3'd1;
  logic          spawn_inverse = 1'b0;
  logic [1:0]    shield_dir_in = 2'd3;
  logic [11:0]   pixel_out;
  logic          valid_out, blocked, hit_player;
  logic [N-1:0]  blocked_mask, hit_mask;
  logic [2:0]    active_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  arrow_pool #(.NUM_ARROWS(N)) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .clear_in(clear_in), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_side(spawn_side), .spawn_speed(spawn_speed), .spawn_inverse(spawn_inverse),
    .shield_dir_in(shield_dir_in), .pixel_out(pixel_out), .valid_out(valid_out),
    .blocked(blocked), .hit_player(hit_player), .blocked_mask(blocked_mask),
    .hit_mask(hit_mask), .active_count(active_count)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Behavioural model: slots as plain integers, updated from the game rules.
  int m_active[N], m_side[N], m_dist[N], m_step[N], m_inv[N];
  int e_pixel = 0, e_valid = 0, e_count = 0, e_bmask = 0, e_hmask = 0;

  function automatic bit box_has(int s, int d, int x, int y);
    int lx, ly, sx, sy;
    if (s < 2) begin lx = 512 - 4; sx = 8;  sy = 32; ly = (s == 0) ? 384 - d - 32 : 384 + d; end
    else       begin ly = 384 - 4; sy = 8;  sx = 32; lx = (s == 2) ? 512 - d - 32 : 512 + d; end
    return (x >= lx) && (x < lx + sx) && (y >= ly) && (y < ly + sy);
  endfunction

  always @(posedge clk) begin
    int free_idx, nd, x, y;
    x = int'(hcount_in);
    y = int'(vcount_in);
    if (rst || clear_in) begin
      for (int i = 0; i < N; i++) m_active[i] = 0;
      e_pixel = 0; e_valid = 0; e_count = 0; e_bmask = 0; e_hmask = 0;
    end else begin
      e_valid = 0; e_pixel = 0; e_count = 0; free_idx = -1;
      for (int i = 0; i < N; i++) begin
        if (m_active[i] != 0 && e_valid == 0 && box_has(m_side[i], m_dist[i], x, y)) begin
          e_valid = 1;
          e_pixel = (m_inv[i] != 0) ? 'h0CF : 'hF00;
        end
        e_count += m_active[i];
        if (m_active[i] == 0 && free_idx < 0) free_idx = i;
      end
      e_bmask = 0; e_hmask = 0;
      if (x == 0 && y == 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_active[i] != 0) begin
            nd = m_dist[i] - m_step[i];
            if (nd < 0) nd = 0;
            if (int'(shield_dir_in) == m_side[i] && m_dist[i] >= 32 && m_dist[i] <= 96) begin
              m_active[i] = 0; e_bmask |= (1 << i);
            end else if (m_inv[i] != 0 && nd <= 128) begin
              m_side[i] = m_side[i] ^ 1; m_dist[i] = 128; m_inv[i] = 0;
            end else if (nd == 0) begin
              m_active[i] = 0; e_hmask |= (1 << i);
            end else begin
              m_dist[i] = nd;
            end
          end
        end
      end
      if (spawn_valid && free_idx >= 0) begin
        m_active[free_idx] = 1;
        m_side[free_idx]   = int'(spawn_side);
        m_dist[free_idx]   = 352;
        m_step[free_idx]   = ((spawn_speed == 0) ? 1 : int'(spawn_speed)) * 2;
        m_inv[free_idx]    = int'(spawn_inverse);
      end
    end
  end

  always @(negedge clk) begin
    int any_free;
    if (!rst) begin
      any_free = 0;
      for (int i = 0; i < N; i++) if (m_active[i] == 0) any_free = 1;
      check("pixel_out", int'(pixel_out), e_pixel);
      check("valid_out", int'(valid_out), e_valid);
      check("active_count", int'(active_count), e_count);
      check("blocked_mask", int'(blocked_mask), e_bmask);
      check("hit_mask", int'(hit_mask), e_hmask);
      check("blocked", int'(blocked), int'(e_bmask != 0));
      check("hit_player", int'(hit_player), int'(e_hmask != 0));
      check("spawn_ready", int'(spawn_ready), any_free);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    hcount_in = 11'd0; vcount_in = 10'd0;
    cyc();
    hcount_in = 11'(IDLE_H); vcount_in = 10'(IDLE_V);
  endtask

  task automatic probe(input int x, input int y);
    hcount_in = 11'(x); vcount_in = 10'(y);
    cyc();
    hcount_in = 11'(IDLE_H); vcount_in = 10'(IDLE_V);
  endtask

  task automatic spawn_one(input int s, input int sp, input int inv);
    spawn_side = 2'(s); spawn_speed = 3'(sp); spawn_inverse = 1'(inv);
    spawn_valid = 1'b1;
    cyc();
    spawn_valid = 1'b0;
  endtask

  task automatic run_until(input int maxk, output int k);
    k = -1;
    for (int n = 1; n <= maxk; n++) begin
      do_tick();
      if (blocked || hit_player) begin k = n; break; end
    end
  endtask

  initial begin
    int k;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("reset pixel_out", int'(pixel_out), 0);
    check("reset active_count", int'(active_count), 0);
    check("reset spawn_ready", int'(spawn_ready), 1);

    // Top arrow, speed 2: 352 / 4 = 88 frames to reach the player.
    shield_dir_in = 2'd3;
    spawn_one(0, 2, 0);
    probe(510, 10);
    check("top sprite colour", int'(pixel_out), 'hF00);
    run_until(120, k);
    check("hit tick count", k, 88);
    check("hit_mask slot0", int'(hit_mask), 1);
    cyc();
    check("hit pulse width", int'(hit_player), 0);
    check("count after hit", int'(active_count), 0);

    // Left arrow into a left shield: blocked when pre-update dist reaches 96.
    shield_dir_in = 2'd2;
    spawn_one(2, 1, 0);
    run_until(200, k);
    check("block tick count", k, 129);
    check("blocked_mask slot0", int'(blocked_mask), 1);
    check("no hit on block", int'(hit_player), 0);
    cyc();

    // Right arrow, speed 4, inverse: flips to left at tick 28, then hits 16 ticks later.
    shield_dir_in = 2'd0;
    spawn_one(3, 4, 1);
    repeat (27) do_tick();
    probe(650, 384);
    check("pending colour", int'(pixel_out), 'h0CF);
    do_tick();
    check("no pulse on flip", int'(hit_player), 0);
    probe(360, 384);
    check("flipped to left colour", int'(pixel_out), 'hF00);
    run_until(40, k);
    check("post-flip hit ticks", k, 16);
    check("flip hit mask", int'(hit_mask), 1);
    cyc();

    // Full pool: fifth spawn waits for slot 2 (speed 7) to free.
    shield_dir_in = 2'd1;
    spawn_one(0, 0, 0);
    spawn_one(1, 1, 0);
    spawn_one(3, 7, 0);
    spawn_one(2, 2, 0);
    check("ready low when full", int'(spawn_ready), 0);
    spawn_side = 2'd0; spawn_speed = 3'd7; spawn_inverse = 1'b0; spawn_valid = 1'b1;
    cyc();
    check("count full", int'(active_count), 4);
    run_until(40, k);
    check("fast slot hit ticks", k, 26);
    check("fast slot hit mask", int'(hit_mask), 'b0100);
    check("ready after free", int'(spawn_ready), 1);
    cyc();
    spawn_valid = 1'b0;
    check("ready low after refill", int'(spawn_ready), 0);
    run_until(40, k);
    check("refilled slot hit ticks", k, 26);
    check("refilled slot index", int'(hit_mask), 'b0100);
    cyc();

    // Clear on a tick with 3 active arrows and a pending spawn.
    clear_in = 1'b1; spawn_valid = 1'b1; hcount_in = 11'd0; vcount_in = 10'd0;
    cyc();
    clear_in = 1'b0; spawn_valid = 1'b0;
    hcount_in = 11'(IDLE_H); vcount_in = 10'(IDLE_V);
    check("clear no block", int'(blocked), 0);
    check("clear no hit", int'(hit_player), 0);
    check("clear count", int'(active_count), 0);
    cyc();
    check("clear spawn rejected", int'(active_count), 0);

    // Render priority: slots 1 and 2 overlap, slot 1 pending inversion.
    shield_dir_in = 2'd3;
    spawn_one(0, 1, 0);
    spawn_one(2, 1, 1);
    spawn_one(2, 1, 0);
    probe(140, 384);
    check("priority colour", int'(pixel_out), 'h0CF);
    check("priority valid", int'(valid_out), 1);
    probe(510, 10);
    check("slot0 colour", int'(pixel_out), 'hF00);
    probe(1000, 700);
    check("empty pixel", int'(pixel_out), 0);
    check("empty valid", int'(valid_out), 0);
    repeat (4) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/arrow_pool.md
# arrow_pool

Multi-slot successor to the single-arrow block. Holds up to `NUM_ARROWS` independent arrows, each flying toward the player at screen centre from one of four sides. Per-arrow speed, optional one-shot inversion (teleport-flip to the opposite side), shield blocking and player-hit detection. Sits between the game-sequencer (spawn source) and the pixel mixer/scoring logic.

## Interface
Parameters:
- `NUM_ARROWS`, 4: slot count (1..8)
- `CENTER_X`, 512: player centre x
- `CENTER_Y`, 384: player centre y
- `START_DIST`, 352: spawn distance of leading edge from centre
- `SPEED_UNIT`, 2: pixels per speed step per frame
- `TURN_DIST`, 128: distance at which a pending inversion fires
- `BLOCK_NEAR`, 32: nearest blocking distance (inclusive)
- `BLOCK_FAR`, 96: farthest blocking distance (inclusive)
- `WIDTH`, 8: sprite width across travel axis
- `HEIGHT`, 32: sprite length along travel axis
- `COLOR`, 12'hF00: normal arrow colour
- `COLOR_INV`, 12'h0CF: colour while an inversion is pending

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `hcount_in` in 11: current pixel x
- `vcount_in` in 10: current pixel y
- `clear_in` in 1: flush all slots (synchronous)
- `spawn_valid` in 1: spawn request
- `spawn_ready` out 1: at least one free slot
- `spawn_side` in 2: 00 top, 01 bottom, 10 left, 11 right
- `spawn_speed` in 3: speed steps; 0 is treated as 1
- `spawn_inverse` in 1: arrow will flip once at `TURN_DIST`
- `shield_dir_in` in 2: side the player's shield faces (same encoding)
- `pixel_out` out 12: arrow colour, or 0
- `valid_out` out 1: an arrow covers the current pixel
- `blocked` out 1: pulse, ≥1 arrow blocked this frame
- `hit_player` out 1: pulse, ≥1 arrow reached the player
- `blocked_mask` out NUM_ARROWS: per-slot block pulse
- `hit_mask` out NUM_ARROWS: per-slot hit pulse
- `active_count` out $clog2(NUM_ARROWS+1): number of occupied slots

## Operation
- Per-slot state:
  - `active`
  - `side` (2b)
  - `dist` (10b, unsigned)
  - `step` (= speed×SPEED_UNIT)
  - `inv_pending`
- Slot FSM: FREE → FLY (on spawn) → FREE (on block, hit or clear).
- Spawn:
  - Accepted when `spawn_valid && spawn_ready`.
  - Goes to the lowest-index free slot.
  - Slot initialised to `dist=START_DIST` and the given side/step/inverse.
- Frame tick is the cycle with `hcount_in==0 && vcount_in==0`. On the tick, each FLY slot evaluates in this priority order:
  1. **Block.** `shield_dir_in==side` and `BLOCK_NEAR ≤ dist ≤ BLOCK_FAR`, using the pre-update dist. Slot goes to FREE and its `blocked_mask` bit is set.
  2. **Move.** `nd = dist − step`, saturating at 0.
  3. **Invert.** If `inv_pending` and `nd ≤ TURN_DIST`:
     - `side ← side ^ 2'b01`
     - `dist ← TURN_DIST`
     - `inv_pending ← 0`
  4. **Hit.** Otherwise, if `nd==0`: slot goes to FREE and its `hit_mask` bit is set.
  5. Otherwise `dist ← nd`.
- A slot accepted on the same cycle as a tick is not moved on that tick.
- Geometry: the leading edge is `dist` pixels from centre on `side`. Sprite box:
  - Top/bottom sides: WIDTH wide × HEIGHT tall, centred on `CENTER_X`.
  - Left/right sides: HEIGHT wide × WIDTH tall, centred on `CENTER_Y`.
  - Coordinate math uses 12-bit signed intermediates. Off-screen portions simply never match.
- Render:
  - The lowest-index active slot whose box contains (hcount, vcount) wins.
  - Colour is `COLOR_INV` if that slot's `inv_pending`, else `COLOR`.
  - No match → `valid_out=0`, `pixel_out=0`.
- `clear_in` and `rst`: all slots go to FREE and all outputs go to 0; neither produces pulses. `clear_in` has priority over a simultaneous spawn and tick.

## Timing
- Reset values: every output is 0, except `spawn_ready`, which is 1 when not in reset (it is combinational from the slot occupancy).
- `spawn_ready = |~active`. It drops in the cycle after the last free slot is taken.
- Spawn latency: the slot is active the cycle after acceptance.
- Block/hit: `blocked`, `hit_player` and the masks are registered. They are high for exactly one cycle, the cycle after the tick.
- Render: `valid_out`/`pixel_out` are registered, with one cycle of latency versus `hcount_in`/`vcount_in`.
- A slot freed on a tick is reusable by a spawn in the following cycle.
- `active_count` is registered and reflects slot state with one cycle of delay.

## Structure
- Shared package `arrow_pkg`:
  - side enum (TOP, BOTTOM, LEFT, RIGHT)
  - slot-state typedef
  - `opposite_side()` function
- Sub-module `arrow_slot`: one slot's FSM, tick update and box test. It exports `active`, `in_box`, `inv_pending` and the block/hit pulses.
- `arrow_pool` holds:
  - NUM_ARROWS `arrow_slot` instances
  - the lowest-free allocator
  - the render priority mux
  - the pulse OR-reduction and popcount

## Test plan
- **Spawn and hit:** side=00, speed=2, no shield, START_DIST=352. Expect 88 ticks, then `hit_player` and `hit_mask[0]` pulse for 1 cycle and `active_count` returns to 0.
- **Block:** side=10, speed=1, `shield_dir_in=10`. Expect `blocked` on the tick where pre-update dist=96, with no `hit_player`.
- **Inversion:** side=11, speed=4, inverse=1. When nd ≤ 128, expect side to become 10, dist=128 and colour to change from 12'h0CF to 12'hF00. The subsequent hit arrives from the left.
- **Full pool:** spawn 5 arrows with NUM_ARROWS=4. Expect `spawn_ready=0` after the 4th. The 5th is held until a slot frees, then accepted into the freed index.
- **Render priority:** overlap slots 1 and 2 with slot 1 inverse-pending. Expect `pixel_out=12'h0CF` one cycle after the overlapping pixel.
- **Clear mid-flight:** assert `clear_in` on a tick cycle with 3 active arrows and `spawn_valid` high. Expect no pulses, `active_count=0` next cycle and the spawn not accepted.
